unsigned_8x8_err_monitor: RTL and testbench
===========================================

UNSIGNED_8X8_ERR_MONITOR -- requirements
Module: unsigned_8x8_err_monitor

Interface
REQ-001 SHALL have parameter N_W, default 16: width of the sample-count request and counters.
REQ-002 SHALL have parameter SUM_W, default 32: width of the absolute-error accumulator.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: pulse that begins a measurement run.
REQ-006 SHALL have port num_samples, input, N_W: samples to accept in the run, sampled when start is accepted.
REQ-007 SHALL have port in_valid, input, 1: x, y and z are valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: the block accepts a sample this cycle.
REQ-009 SHALL have port x, input, 8: multiplier operand.
REQ-010 SHALL have port y, input, 8: multiplicand operand.
REQ-011 SHALL have port z, input, 16: approximate product from the 8x8 approximate multiplier under test.
REQ-012 SHALL have port busy, output, 1: high in RUN and DRAIN.
REQ-013 SHALL have port done, output, 1: high in DONE; results are stable.
REQ-014 SHALL have port err_cnt, output, N_W: number of samples with z != x*y.
REQ-015 SHALL have port sum_abs_err, output, SUM_W: sum of |z - x*y|.
REQ-016 SHALL have port sum_err, output, SUM_W+1: signed two's-complement sum of (z - x*y).
REQ-017 SHALL have port max_abs_err, output, 16: largest |z - x*y| in the run.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE or DONE, start=1 SHALL clear all four result registers, latch num_samples, and go to RUN, or straight to DONE when num_samples=0.
REQ-020 In RUN or DRAIN, start SHALL be ignored.
REQ-021 in_ready SHALL equal 1 only in RUN while accepted < latched num_samples; a sample is accepted when in_valid and in_ready are both 1.
REQ-022 Pipeline stage 1 SHALL register the accepted sample, the exact 16-bit product x*y, and a stage-valid bit.
REQ-023 Stage 2 SHALL compute the signed 17-bit difference e = z - x*y and a 16-bit |e|.
REQ-024 Stage 2 SHALL then update the accumulators in the same cycle: err_cnt += (e!=0), sum_abs_err += |e|, sum_err += e, max_abs_err = max(max_abs_err, |e|).
REQ-025 sum_abs_err SHALL saturate at 2^SUM_W-1.
REQ-026 sum_err SHALL saturate at +(2^SUM_W-1) and at -2^SUM_W.
REQ-027 err_cnt SHALL NOT wrap.
REQ-028 Accepting the final sample SHALL move RUN to DRAIN; DRAIN SHALL move to DONE once both pipeline stages are empty.
REQ-029 done SHALL therefore rise exactly 2 cycles after the last acceptance edge, with all results final.
REQ-030 done SHALL stay high, and results SHALL hold, until the next accepted start or reset.
REQ-031 in_valid outside RUN SHALL have no effect; x, y and z SHALL be don't-care when not accepted.
REQ-032 A cycle with in_valid=0 in RUN SHALL insert a bubble and SHALL NOT change any accumulator.

Reset
REQ-033 Asserting rst at any time, including mid-run with the pipeline full, SHALL immediately force state to IDLE.
REQ-034 Asserting rst SHALL clear both stage-valid bits, the sample counter, latched num_samples and all result outputs to 0.
REQ-035 Asserting rst SHALL drive in_ready, busy and done to 0.
REQ-036 After rst deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-037 start, num_samples=1; sample x=3, y=5, z=12 -> done 2 cycles after acceptance; err_cnt=1, sum_abs_err=3, sum_err=-3, max_abs_err=3.
REQ-038 num_samples=3: (255,255,65025), (16,16,272), (7,9,60) -> err_cnt=2, sum_abs_err=19, sum_err=13, max_abs_err=16.
REQ-039 start with num_samples=0 -> done on the next cycle, all results 0, in_ready never high.
REQ-040 num_samples=2 with in_valid toggling 1,0,0,1 -> exactly 2 accepted; the extra in_valid after the second acceptance is ignored; start asserted during DRAIN is ignored.
REQ-041 rst asserted for 1 cycle while 2 samples are in flight -> all outputs 0 and IDLE immediately; a new run of 1 sample (x=2, y=2, z=4) gives err_cnt=0 and sum_abs_err=0.
REQ-042 SUM_W=8, 2 samples each with |e|=200 -> sum_abs_err saturates at 255 and sum_err saturates at 255 when z > x*y.

Source files
------------

// File: rtl/unsigned_8x8_err_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier: compares each
// accepted z against the exact x*y and accumulates count, |e| sum, signed sum and max.
module unsigned_8x8_err_monitor #(
    parameter int N_W   = 16,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    input  logic [15:0]      z,
    output logic             busy,
    output logic             done,
    output logic [N_W-1:0]   err_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [SUM_W:0]   sum_err,
    output logic [15:0]      max_abs_err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int AW = SUM_W + 17;
    localparam int EW = SUM_W + 18;
    localparam logic        [SUM_W-1:0] SABS_MAX = {SUM_W{1'b1}};
    localparam logic signed [SUM_W:0]   SERR_MAX = {1'b0, {SUM_W{1'b1}}};
    localparam logic signed [SUM_W:0]   SERR_MIN = {1'b1, {SUM_W{1'b0}}};

    state_t              state_q;
    logic [N_W-1:0]      n_q, cnt_q;
    logic                s1_vld_q, s2_vld_q;
    logic [15:0]         s1_z_q, s1_p_q;
    logic [N_W-1:0]      err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]    sum_abs_q, sum_abs_d;
    logic signed [SUM_W:0] sum_err_q, sum_err_d;
    logic [15:0]         max_abs_q, max_abs_d;

    logic                accept;
    logic signed [16:0]  e;
    logic [15:0]         abs_e;
    logic [AW-1:0]       abs_sum;
    logic signed [EW-1:0] err_sum;

    assign in_ready = (state_q == RUN) && (cnt_q < n_q);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    assign err_cnt     = err_cnt_q;
    assign sum_abs_err = sum_abs_q;
    assign sum_err     = sum_err_q;
    assign max_abs_err = max_abs_q;

    // Stage 2: error of the registered sample, folded into saturating accumulators
    // computed wide enough that overflow is just a compare against the limit.
    always_comb begin
        e         = $signed({1'b0, s1_z_q}) - $signed({1'b0, s1_p_q});
        abs_e     = e[16] ? 16'(-e) : e[15:0];
        abs_sum   = AW'(sum_abs_q) + AW'(abs_e);
        err_sum   = EW'(sum_err_q) + EW'(e);
        sum_abs_d = (abs_sum > AW'(SABS_MAX)) ? SABS_MAX : abs_sum[SUM_W-1:0];
        if (err_sum > EW'(SERR_MAX))
            sum_err_d = SERR_MAX;
        else if (err_sum < EW'(SERR_MIN))
            sum_err_d = SERR_MIN;
        else
            sum_err_d = err_sum[SUM_W:0];
        err_cnt_d = ((e != 17'sd0) && (err_cnt_q != {N_W{1'b1}})) ? err_cnt_q + N_W'(1) : err_cnt_q;
        max_abs_d = (abs_e > max_abs_q) ? abs_e : max_abs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s1_z_q    <= '0;
            s1_p_q    <= '0;
            err_cnt_q <= '0;
            sum_abs_q <= '0;
            sum_err_q <= '0;
            max_abs_q <= '0;
        end else begin
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            if (accept) begin
                s1_z_q <= z;
                s1_p_q <= 16'(x) * 16'(y);
            end
            if (s1_vld_q) begin
                err_cnt_q <= err_cnt_d;
                sum_abs_q <= sum_abs_d;
                sum_err_q <= sum_err_d;
                max_abs_q <= max_abs_d;
            end
            case (state_q)
                IDLE, DONE: if (start) begin
                    n_q       <= num_samples;
                    cnt_q     <= '0;
                    err_cnt_q <= '0;
                    sum_abs_q <= '0;
                    sum_err_q <= '0;
                    max_abs_q <= '0;
                    state_q   <= (num_samples == '0) ? DONE : RUN;
                end
                RUN: if (accept) begin
                    cnt_q <= cnt_q + N_W'(1);
                    if ((cnt_q + N_W'(1)) == n_q) state_q <= DRAIN;
                end
                // Last sample has left stage 1 and is retiring from stage 2 this edge.
                DRAIN: if (!s1_vld_q && s2_vld_q) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unsigned_8x8_err_monitor.sv
// Directed + randomized bench; two instances (SUM_W=32 and SUM_W=8) share stimulus
// and are checked against a saturating arithmetic model.
module tb_unsigned_8x8_err_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  x = '0, y = '0;
    logic [15:0] z = '0;

    logic        in_ready, busy, done;
    logic [15:0] err_cnt, max_abs_err;
    logic [31:0] sum_abs_err;
    logic [32:0] sum_err;
    logic        in_ready8, busy8, done8;
    logic [15:0] err_cnt8, max_abs_err8;
    logic [7:0]  sum_abs_err8;
    logic [8:0]  sum_err8;

    int checks = 0, errors = 0;
    longint m_cnt, m_max, m_abs32, m_err32, m_abs8, m_err8;
    logic [7:0]  qx[$], qy[$];
    logic [15:0] qz[$];

    unsigned_8x8_err_monitor dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z(z),
        .busy(busy), .done(done), .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
        .sum_err(sum_err), .max_abs_err(max_abs_err));

    unsigned_8x8_err_monitor #(.N_W(16), .SUM_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready8), .x(x), .y(y), .z(z),
        .busy(busy8), .done(done8), .err_cnt(err_cnt8), .sum_abs_err(sum_abs_err8),
        .sum_err(sum_err8), .max_abs_err(max_abs_err8));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_max = 0; m_abs32 = 0; m_err32 = 0; m_abs8 = 0; m_err8 = 0;
    endtask

    task automatic model_add(input longint xx, input longint yy, input longint zz);
        longint e, a;
        e = zz - xx * yy;
        a = (e < 0) ? -e : e;
        if (e != 0) m_cnt++;
        if (a > m_max) m_max = a;
        m_abs32 = clamp(m_abs32 + a, 0, (64'sd1 << 32) - 1);
        m_err32 = clamp(m_err32 + e, -(64'sd1 << 32), (64'sd1 << 32) - 1);
        m_abs8  = clamp(m_abs8 + a, 0, 255);
        m_err8  = clamp(m_err8 + e, -256, 255);
    endtask

    task automatic chk_results(input string tag);
        chk({tag, ".err_cnt"}, longint'(err_cnt), m_cnt);
        chk({tag, ".sum_abs"}, longint'(sum_abs_err), m_abs32);
        chk({tag, ".sum_err"}, longint'($signed(sum_err)), m_err32);
        chk({tag, ".max_abs"}, longint'(max_abs_err), m_max);
        chk({tag, ".w8.sum_abs"}, longint'(sum_abs_err8), m_abs8);
        chk({tag, ".w8.sum_err"}, longint'($signed(sum_err8)), m_err8);
        chk({tag, ".w8.err_cnt"}, longint'(err_cnt8), m_cnt);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
        qx.push_back(a); qy.push_back(b); qz.push_back(c);
    endtask

    // vmode: 0 = valid every cycle, 1 = random bubbles, 2 = 1,0,0,1 pattern
    task automatic run(input int n, input int vmode, input string tag);
        int idx, cyc;
        logic v;
        model_clear();
        @(negedge clk); start = 1'b1; num_samples = 16'(n); in_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        if (n == 0) begin
            chk({tag, ".done"}, longint'(done), 1);
            chk({tag, ".in_ready"}, longint'(in_ready), 0);
            chk({tag, ".busy"}, longint'(busy), 0);
            chk_results(tag);
            @(negedge clk);
            chk({tag, ".in_ready2"}, longint'(in_ready), 0);
            chk({tag, ".done2"}, longint'(done), 1);
        end else begin
            chk({tag, ".busy"}, longint'(busy), 1);
            chk_results({tag, ".clr"});
            idx = 0; cyc = 0;
            while (idx < n && cyc < 500) begin
                v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ($urandom_range(0, 2) != 0) : (cyc % 3 == 0);
                chk({tag, ".in_ready_run"}, longint'(in_ready), 1);
                in_valid = v;
                x = v ? qx[idx] : 8'($urandom);
                y = v ? qy[idx] : 8'($urandom);
                z = v ? qz[idx] : 16'($urandom);
                @(posedge clk);
                if (v) begin
                    model_add(longint'(qx[idx]), longint'(qy[idx]), longint'(qz[idx]));
                    idx++;
                end
                @(negedge clk); cyc++;
            end
            chk({tag, ".accepted"}, idx, n);
            in_valid = 1'b1; x = 8'($urandom); y = 8'($urandom); z = 16'($urandom);
            start = 1'b1; num_samples = 16'd5;
            chk({tag, ".drain_ready"}, longint'(in_ready), 0);
            chk({tag, ".drain_busy"}, longint'(busy), 1);
            chk({tag, ".drain_done"}, longint'(done), 0);
            @(negedge clk); start = 1'b0;
            chk({tag, ".done_t1"}, longint'(done), 0);
            @(negedge clk); in_valid = 1'b0;
            chk({tag, ".done_t2"}, longint'(done), 1);
            chk({tag, ".busy_t2"}, longint'(busy), 0);
            chk_results(tag);
            @(negedge clk);
            chk({tag, ".done_hold"}, longint'(done), 1);
            chk_results({tag, ".hold"});
        end
        qx.delete(); qy.delete(); qz.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        model_clear();
        chk("reset.busy", longint'(busy), 0);
        chk("reset.done", longint'(done), 0);
        chk("reset.in_ready", longint'(in_ready), 0);
        chk_results("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle.busy", longint'(busy), 0);
        chk("idle.done", longint'(done), 0);

        push(3, 5, 12);                                  run(1, 0, "one");
        push(255, 255, 65025); push(16, 16, 272); push(7, 9, 60);
                                                          run(3, 0, "three");
        run(0, 0, "zero");
        push(4, 4, 20); push(9, 9, 70);                  run(2, 2, "toggle");
        push(10, 10, 300); push(0, 0, 200);              run(2, 0, "sat_pos");
        push(255, 255, 64825); push(100, 100, 9800); push(0, 0, 65535);
                                                          run(3, 1, "sat_neg");

        // Reset with two samples in flight
        model_clear();
        @(negedge clk); start = 1'b1; num_samples = 16'd4;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; x = 8'd200; y = 8'd3; z = 16'd0;
        @(negedge clk); x = 8'd17; y = 8'd17; z = 16'd1;
        @(negedge clk); in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid.busy", longint'(busy), 0);
        chk("rst_mid.done", longint'(done), 0);
        chk("rst_mid.in_ready", longint'(in_ready), 0);
        chk_results("rst_mid");
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_idle.busy", longint'(busy), 0);
        chk("rst_idle.done", longint'(done), 0);
        push(2, 2, 4);                                   run(1, 0, "after_rst");

        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                logic [7:0] a, b;
                int p, d;
                a = 8'($urandom); b = 8'($urandom);
                p = int'(a) * int'(b);
                case ($urandom_range(0, 2))
                    0: d = 0;
                    1: d = int'($urandom_range(0, 64)) - 32;
                    default: d = int'($urandom_range(0, 65535)) - p;
                endcase
                push(a, b, 16'(clamp(longint'(p + d), 0, 65535)));
            end
            run(n, 1, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
